// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, the control inputs
// from EXEC/ID and the IF/ID pipeline register consumed by decode.
interface if_stage_if;
   // instruction memory request/response
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   // pipeline control
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   // IF/ID pipeline register
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;

   // fetch stage side
   modport master (
      output imem_req, imem_addr,
      output ifid_valid, ifid_instr, ifid_pc, ifid_pc4,
      input  imem_ack, imem_rdata,
      input  stall, redirect, redirect_pc
   );

   // memory / pipeline environment side
   modport slave (
      input  imem_req, imem_addr,
      input  ifid_valid, ifid_instr, ifid_pc, ifid_pc4,
      output imem_ack, imem_rdata,
      output stall, redirect, redirect_pc
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// loads the IF/ID register, parks one word in a hold buffer while decode
// stalls, and drops in-flight words after a branch/jump redirect.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   if_stage_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;           // next address to fetch (redirect target in DISCARD)
   logic [31:0] r_disc_addr;    // address of the request being thrown away
   logic [31:0] r_hold_instr;
   logic [31:0] r_hold_pc;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc4;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic [31:0] w_disc_addr_next;
   logic [31:0] w_hold_instr_next;
   logic [31:0] w_hold_pc_next;
   logic        w_ifid_valid_next;
   logic [31:0] w_ifid_instr_next;
   logic [31:0] w_ifid_pc_next;
   logic [31:0] w_ifid_pc4_next;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_hold_pc_plus4;
   logic [31:0] w_target;
   logic        w_ifid_can_load;

   assign w_pc_plus4      = r_pc + 32'd4;
   assign w_hold_pc_plus4 = r_hold_pc + 32'd4;
   // low two bits of the target are dropped so fetches stay word aligned
   assign w_target        = bus.redirect_pc & 32'hFFFF_FFFC;
   // IF/ID can take a new word when decode consumes or the slot is empty
   assign w_ifid_can_load = !bus.stall || !r_ifid_valid;

   // memory request is a pure function of registered state
   assign bus.imem_req  = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
   assign bus.imem_addr = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;

   assign bus.ifid_valid = r_ifid_valid;
   assign bus.ifid_instr = r_ifid_instr;
   assign bus.ifid_pc    = r_ifid_pc;
   assign bus.ifid_pc4   = r_ifid_pc4;

   // next-state, PC, hold buffer and IF/ID register update
   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_disc_addr_next  = r_disc_addr;
      w_hold_instr_next = r_hold_instr;
      w_hold_pc_next    = r_hold_pc;
      w_ifid_valid_next = r_ifid_valid;
      w_ifid_instr_next = r_ifid_instr;
      w_ifid_pc_next    = r_ifid_pc;
      w_ifid_pc4_next   = r_ifid_pc4;

      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_FETCH;
         end

         ST_FETCH: begin
            if (bus.redirect) begin
               // redirect wins over stall; any returning word is dropped
               w_ifid_valid_next = 1'b0;
               w_pc_next         = w_target;
               w_hold_instr_next = 32'd0;
               w_hold_pc_next    = 32'd0;
               if (!bus.imem_ack) begin
                  // request still outstanding: keep presenting its address
                  w_disc_addr_next = r_pc;
                  w_state_next     = ST_DISCARD;
               end
            end else if (bus.imem_ack) begin
               w_pc_next = w_pc_plus4;
               if (w_ifid_can_load) begin
                  w_ifid_valid_next = 1'b1;
                  w_ifid_instr_next = bus.imem_rdata;
                  w_ifid_pc_next    = r_pc;
                  w_ifid_pc4_next   = w_pc_plus4;
               end else begin
                  // decode is blocked: park the word until it frees up
                  w_hold_instr_next = bus.imem_rdata;
                  w_hold_pc_next    = r_pc;
                  w_state_next      = ST_HOLD;
               end
            end else if (!bus.stall) begin
               // decode consumed its word and nothing new arrived
               w_ifid_valid_next = 1'b0;
            end
         end

         ST_HOLD: begin
            if (bus.redirect) begin
               w_ifid_valid_next = 1'b0;
               w_pc_next         = w_target;
               w_hold_instr_next = 32'd0;
               w_hold_pc_next    = 32'd0;
               w_state_next      = ST_FETCH;
            end else if (!bus.stall) begin
               w_ifid_valid_next = 1'b1;
               w_ifid_instr_next = r_hold_instr;
               w_ifid_pc_next    = r_hold_pc;
               w_ifid_pc4_next   = w_hold_pc_plus4;
               w_state_next      = ST_FETCH;
            end
         end

         ST_DISCARD: begin
            // IF/ID is already invalid here; stalls change nothing
            w_ifid_valid_next = 1'b0;
            if (bus.redirect) begin
               // newer target replaces the stored one; old request still owed
               w_pc_next = w_target;
            end
            if (bus.imem_ack) begin
               w_state_next = ST_FETCH;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_disc_addr  <= 32'd0;
         r_hold_instr <= 32'd0;
         r_hold_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= 32'd0;
         r_ifid_pc    <= 32'd0;
         r_ifid_pc4   <= 32'd0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_disc_addr  <= w_disc_addr_next;
         r_hold_instr <= w_hold_instr_next;
         r_hold_pc    <= w_hold_pc_next;
         r_ifid_valid <= w_ifid_valid_next;
         r_ifid_instr <= w_ifid_instr_next;
         r_ifid_pc    <= w_ifid_pc_next;
         r_ifid_pc4   <= w_ifid_pc4_next;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table covering streaming,
// wait states, stalls and redirects, plus hand sequences for async reset and
// PC wraparound at the top of the address space.
module tb_if_stage;

   logic clk;
   logic rst_n;
   logic rst2_n;

   if_stage_if u_bus ();
   if_stage_if u_bus2 ();

   if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.master)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk   (clk),
      .rst_n (rst2_n),
      .bus   (u_bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] DATA_TAG = 32'hC0DE_0000;

   // one record per clock cycle: inputs driven that cycle, outputs seen that cycle
   typedef struct {
      logic        ack;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   localparam int NVEC = 36;
   vec_t tbl [NVEC];

   int n_checks = 0;
   int n_errors = 0;

   function automatic vec_t mk(input logic ack, input logic stall, input logic redir,
                               input logic [31:0] rpc, input logic req,
                               input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc);
      vec_t v;
      v.ack = ack; v.stall = stall; v.redir = redir; v.rpc = rpc;
      v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s [%0d]: got %08h expected %08h", name, idx, act, exp);
      end
   endtask

   initial begin
      //          ack stall rdr rpc            req addr           vld pc
      tbl[0]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);    // IDLE
      tbl[1]  = mk(1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      tbl[2]  = mk(1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0);
      tbl[3]  = mk(1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h4);
      tbl[4]  = mk(0, 0, 0, 32'h0,          1, 32'hC,          1, 32'h8);    // wait states
      tbl[5]  = mk(0, 0, 0, 32'h0,          1, 32'hC,          0, 32'h0);
      tbl[6]  = mk(0, 0, 0, 32'h0,          1, 32'hC,          0, 32'h0);
      tbl[7]  = mk(1, 0, 0, 32'h0,          1, 32'hC,          0, 32'h0);
      tbl[8]  = mk(1, 0, 0, 32'h0,          1, 32'h10,         1, 32'hC);
      tbl[9]  = mk(1, 1, 0, 32'h0,          1, 32'h14,         1, 32'h10);   // -> HOLD
      tbl[10] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h10);
      tbl[11] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h10);
      tbl[12] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h10);
      tbl[13] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10);   // release
      tbl[14] = mk(1, 0, 0, 32'h0,          1, 32'h18,         1, 32'h14);
      tbl[15] = mk(1, 0, 1, 32'h100,        1, 32'h1C,         1, 32'h18);   // redirect+ack
      tbl[16] = mk(0, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
      tbl[17] = mk(1, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
      tbl[18] = mk(0, 0, 1, 32'h203,        1, 32'h104,        1, 32'h100);  // -> DISCARD
      tbl[19] = mk(0, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
      tbl[20] = mk(1, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
      tbl[21] = mk(1, 0, 0, 32'h0,          1, 32'h200,        0, 32'h0);
      tbl[22] = mk(1, 0, 0, 32'h0,          1, 32'h204,        1, 32'h200);
      tbl[23] = mk(0, 1, 0, 32'h0,          1, 32'h208,        1, 32'h204);  // stall, no ack
      tbl[24] = mk(0, 1, 0, 32'h0,          1, 32'h208,        1, 32'h204);
      tbl[25] = mk(1, 0, 0, 32'h0,          1, 32'h208,        1, 32'h204);
      tbl[26] = mk(0, 0, 0, 32'h0,          1, 32'h20C,        1, 32'h208);
      tbl[27] = mk(1, 1, 0, 32'h0,          1, 32'h20C,        0, 32'h0);    // stall, empty slot
      tbl[28] = mk(1, 1, 0, 32'h0,          1, 32'h210,        1, 32'h20C);  // -> HOLD
      tbl[29] = mk(0, 1, 1, 32'h300,        0, 32'h0,          1, 32'h20C);  // redirect in HOLD
      tbl[30] = mk(1, 0, 0, 32'h0,          1, 32'h300,        0, 32'h0);
      tbl[31] = mk(0, 0, 1, 32'h400,        1, 32'h304,        1, 32'h300);  // -> DISCARD
      tbl[32] = mk(0, 0, 1, 32'h501,        1, 32'h304,        0, 32'h0);    // retarget
      tbl[33] = mk(1, 0, 0, 32'h0,          1, 32'h304,        0, 32'h0);
      tbl[34] = mk(1, 0, 0, 32'h0,          1, 32'h500,        0, 32'h0);
      tbl[35] = mk(0, 0, 0, 32'h0,          1, 32'h504,        1, 32'h500);

      rst_n = 1'b0;
      rst2_n = 1'b0;
      u_bus.imem_ack = 1'b0;  u_bus.imem_rdata = 32'd0;
      u_bus.stall = 1'b0;     u_bus.redirect = 1'b0;  u_bus.redirect_pc = 32'd0;
      u_bus2.imem_ack = 1'b0; u_bus2.imem_rdata = 32'd0;
      u_bus2.stall = 1'b0;    u_bus2.redirect = 1'b0; u_bus2.redirect_pc = 32'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_req",   0, {31'd0, u_bus.imem_req},   32'd0);
      chk("reset_valid", 0, {31'd0, u_bus.ifid_valid}, 32'd0);
      chk("reset_instr", 0, u_bus.ifid_instr,          32'd0);
      chk("reset_pc",    0, u_bus.ifid_pc,             32'd0);
      chk("reset_pc4",   0, u_bus.ifid_pc4,            32'd0);
      rst_n = 1'b1;

      // vector table, one row per cycle
      for (int i = 0; i < NVEC; i++) begin
         if (i > 0) @(negedge clk);
         chk("imem_req", i, {31'd0, u_bus.imem_req}, {31'd0, tbl[i].exp_req});
         if (tbl[i].exp_req)
            chk("imem_addr", i, u_bus.imem_addr, tbl[i].exp_addr);
         chk("ifid_valid", i, {31'd0, u_bus.ifid_valid}, {31'd0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk("ifid_pc",    i, u_bus.ifid_pc,    tbl[i].exp_pc);
            chk("ifid_instr", i, u_bus.ifid_instr, DATA_TAG + tbl[i].exp_pc);
            chk("ifid_pc4",   i, u_bus.ifid_pc4,   tbl[i].exp_pc + 32'd4);
         end
         $display("row %0d: ack=%0b stall=%0b redir=%0b req=%0b addr=%08h valid=%0b pc=%08h",
                  i, tbl[i].ack, tbl[i].stall, tbl[i].redir, u_bus.imem_req,
                  u_bus.imem_addr, u_bus.ifid_valid, u_bus.ifid_pc);
         u_bus.imem_ack    = tbl[i].ack;
         u_bus.imem_rdata  = tbl[i].ack ? (DATA_TAG + tbl[i].exp_addr) : 32'hDEAD_BEEF;
         u_bus.stall       = tbl[i].stall;
         u_bus.redirect    = tbl[i].redir;
         u_bus.redirect_pc = tbl[i].rpc;
      end

      // asynchronous reset in the middle of a cycle with a request pending
      @(negedge clk);
      u_bus.imem_ack = 1'b0;
      u_bus.redirect = 1'b0;
      u_bus.stall    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_req",   0, {31'd0, u_bus.imem_req},   32'd0);
      chk("async_valid", 0, {31'd0, u_bus.ifid_valid}, 32'd0);
      chk("async_pc",    0, u_bus.ifid_pc,             32'd0);
      $display("async reset: req=%0b valid=%0b", u_bus.imem_req, u_bus.ifid_valid);

      // wraparound instance: zero-wait memory from RESET_PC = FFFF_FFF8
      @(negedge clk);
      rst2_n = 1'b1;
      chk("wrap_idle_req", 0, {31'd0, u_bus2.imem_req}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         logic [31:0] exp_addr;
         logic [31:0] exp_pc;
         exp_addr = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
         exp_pc   = exp_addr - 32'd4;
         @(negedge clk);
         chk("wrap_req",  c, {31'd0, u_bus2.imem_req}, 32'd1);
         chk("wrap_addr", c, u_bus2.imem_addr, exp_addr);
         if (c >= 2) begin
            chk("wrap_valid", c, {31'd0, u_bus2.ifid_valid}, 32'd1);
            chk("wrap_pc",    c, u_bus2.ifid_pc,    exp_pc);
            chk("wrap_instr", c, u_bus2.ifid_instr, DATA_TAG + exp_pc);
            chk("wrap_pc4",   c, u_bus2.ifid_pc4,   exp_addr);
         end
         $display("wrap cycle %0d: addr=%08h valid=%0b pc=%08h pc4=%08h", c,
                  u_bus2.imem_addr, u_bus2.ifid_valid, u_bus2.ifid_pc, u_bus2.ifid_pc4);
         u_bus2.imem_ack   = 1'b1;
         u_bus2.imem_rdata = DATA_TAG + exp_addr;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
